// File: rtl/clksel_sequencer_if.sv
// Request/status bundle between the host-side clock-select sequencer and its controller.
// The master side drives the requests; the slave side is the sequencer itself.
interface clksel_sequencer_if;
    logic       fast_req;
    logic       en_hs;
    logic       div_wr;
    logic [1:0] div_wdata;
    logic       err_clr;
    logic       hsclk_selected;
    logic       lsclk_selected;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       cpu_rdy;
    logic       switch_err;
    logic [1:0] state;

    modport master (
        output fast_req, en_hs, div_wr, div_wdata, err_clr, hsclk_selected, lsclk_selected,
        input  hsclk_sel, cpuclk_div_sel, cpu_rdy, switch_err, state
    );

    modport slave (
        input  fast_req, en_hs, div_wr, div_wdata, err_clr, hsclk_selected, lsclk_selected,
        output hsclk_sel, cpuclk_div_sel, cpu_rdy, switch_err, state
    );
endinterface

// File: rtl/clksel_sequencer.sv
// Slow-domain sequencer for clkctrl_phi2: requests the fast clock, stalls the CPU during a switch,
// owns the CPU clock divider and falls back to the slow clock with a sticky error on timeout.
module clksel_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned MIN_LS_CYCLES  = 4,
    parameter int unsigned CNT_W          = 4,
    parameter logic [1:0]  RESET_DIV      = 2'b00
) (
    input  logic                lsclk_in,
    input  logic                rst_b,
    clksel_sequencer_if.slave   bus
);

    localparam int unsigned DIV_W = 2;

    typedef enum logic [1:0] {
        LS_RUN = 2'b00,
        TO_HS  = 2'b01,
        HS_RUN = 2'b10,
        TO_LS  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic               hsclk_sel_q, hsclk_sel_d;
    logic               cpu_rdy_q, cpu_rdy_d;
    logic               switch_err_q, switch_err_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0]   pend_val_q, pend_val_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   holdoff_q, holdoff_d;
    logic               sync1_q, sync2_q;

    logic hs_sel_s;
    logic apply_div, go_hs, timer_exp, hs_done, hs_tmo, go_ls, ls_done, ls_tmo, err_set;

    assign hs_sel_s  = sync2_q;
    assign timer_exp = (timer_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign apply_div = (state_q == LS_RUN) && pend_vld_q;
    // A pending divider apply takes the cycle; the switch request waits one more.
    assign go_hs     = (state_q == LS_RUN) && !pend_vld_q && bus.en_hs && bus.fast_req &&
                       (holdoff_q == '0) && !switch_err_q;
    assign hs_done   = (state_q == TO_HS) && hs_sel_s;
    assign hs_tmo    = (state_q == TO_HS) && !hs_sel_s && timer_exp;
    assign go_ls     = (state_q == HS_RUN) && (!bus.fast_req || !bus.en_hs);
    assign ls_done   = (state_q == TO_LS) && (bus.lsclk_selected || timer_exp);
    assign ls_tmo    = (state_q == TO_LS) && timer_exp;

    // State register
    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) state_q <= LS_RUN;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LS_RUN: if (go_hs)   state_d = TO_HS;
            TO_HS:  if (hs_done) state_d = HS_RUN;
                    else if (hs_tmo) state_d = TO_LS;
            HS_RUN: if (go_ls)   state_d = TO_LS;
            TO_LS:  if (ls_done) state_d = LS_RUN;
            default: state_d = LS_RUN;
        endcase
    end

    // Registered outputs and datapath next values
    always_comb begin
        hsclk_sel_d = hsclk_sel_q;
        cpu_rdy_d   = cpu_rdy_q;
        timer_d     = timer_q;
        holdoff_d   = holdoff_q;
        err_set     = 1'b0;
        case (state_q)
            LS_RUN: begin
                if (holdoff_q != '0) holdoff_d = holdoff_q - CNT_W'(1);
                if (go_hs) begin
                    hsclk_sel_d = 1'b1;
                    cpu_rdy_d   = 1'b0;
                    timer_d     = '0;
                end
            end
            TO_HS: begin
                timer_d = timer_q + CNT_W'(1);
                if (hs_done) begin
                    cpu_rdy_d = 1'b1;
                end else if (hs_tmo) begin
                    hsclk_sel_d = 1'b0;
                    err_set     = 1'b1;
                    timer_d     = '0;
                end
            end
            HS_RUN: begin
                hsclk_sel_d = 1'b1;
                cpu_rdy_d   = 1'b1;
                if (go_ls) begin
                    hsclk_sel_d = 1'b0;
                    cpu_rdy_d   = 1'b0;
                    timer_d     = '0;
                end
            end
            TO_LS: begin
                timer_d = timer_q + CNT_W'(1);
                if (ls_done) begin
                    cpu_rdy_d = 1'b1;
                    holdoff_d = CNT_W'(MIN_LS_CYCLES);
                end
                if (ls_tmo) err_set = 1'b1;
            end
            default: ;
        endcase

        switch_err_d = switch_err_q;
        if (bus.err_clr) switch_err_d = 1'b0;
        if (err_set)     switch_err_d = 1'b1;

        div_d      = div_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        if (apply_div) begin
            div_d      = pend_val_q;
            pend_vld_d = 1'b0;
        end
        // A write in the apply cycle refills the pending slot.
        if (bus.div_wr) begin
            pend_vld_d = 1'b1;
            pend_val_d = bus.div_wdata;
        end
    end

    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            hsclk_sel_q  <= 1'b0;
            cpu_rdy_q    <= 1'b1;
            switch_err_q <= 1'b0;
            div_q        <= RESET_DIV;
            pend_vld_q   <= 1'b0;
            pend_val_q   <= '0;
            timer_q      <= '0;
            holdoff_q    <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
        end else begin
            hsclk_sel_q  <= hsclk_sel_d;
            cpu_rdy_q    <= cpu_rdy_d;
            switch_err_q <= switch_err_d;
            div_q        <= div_d;
            pend_vld_q   <= pend_vld_d;
            pend_val_q   <= pend_val_d;
            timer_q      <= timer_d;
            holdoff_q    <= holdoff_d;
            sync1_q      <= bus.hsclk_selected;
            sync2_q      <= sync1_q;
        end
    end

    assign bus.hsclk_sel      = hsclk_sel_q;
    assign bus.cpu_rdy        = cpu_rdy_q;
    assign bus.switch_err     = switch_err_q;
    assign bus.cpuclk_div_sel = div_q;
    assign bus.state          = state_q;

endmodule

// File: tb/tb_clksel_sequencer.sv
// Scoreboard bench for clksel_sequencer: expected per-cycle snapshots are queued with the stimulus
// and popped against the DUT outputs sampled on the falling edge.
module tb_clksel_sequencer;

    typedef struct packed {
        logic [1:0] st;
        logic       hs;
        logic       rdy;
        logic [1:0] div;
        logic       err;
    } exp_t;

    localparam logic [1:0] S_LS  = 2'b00;
    localparam logic [1:0] S_THS = 2'b01;
    localparam logic [1:0] S_HS  = 2'b10;
    localparam logic [1:0] S_TLS = 2'b11;

    logic clk;
    logic rst_b;
    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];

    clksel_sequencer_if bus ();

    clksel_sequencer dut (
        .lsclk_in (clk),
        .rst_b    (rst_b),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic [1:0] st, logic hs, logic rdy, logic [1:0] div, logic err);
        exp_t e;
        e.st = st; e.hs = hs; e.rdy = rdy; e.div = div; e.err = err;
        return e;
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.st = bus.state; o.hs = bus.hsclk_sel; o.rdy = bus.cpu_rdy;
        o.div = bus.cpuclk_div_sel; o.err = bus.switch_err;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        bus.fast_req = 1'b0; bus.en_hs = 1'b0; bus.div_wr = 1'b0; bus.div_wdata = 2'b00;
        bus.err_clr = 1'b0; bus.hsclk_selected = 1'b0; bus.lsclk_selected = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst_b = 1'b0;
        bus.fast_req = 1'b0; bus.en_hs = 1'b0; bus.div_wr = 1'b0; bus.div_wdata = 2'b00;
        bus.err_clr = 1'b0; bus.hsclk_selected = 1'b0; bus.lsclk_selected = 1'b1;
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        @(negedge clk);
        o = obs(); e = exp_q.pop_front(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL reset_held: got %b want %b", o, e); end
        rst_b = 1'b1;
        tick();
        o = obs(); e = exp_q.pop_front(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL reset_idle: got %b want %b", o, e); end
    endtask

    task automatic test_hs_entry();
        exp_t e, o;
        do_reset();
        bus.fast_req = 1'b1; bus.en_hs = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(S_THS, 1'b1, 1'b0, 2'b00, 1'b0));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(S_HS, 1'b1, 1'b1, 2'b00, 1'b0));
        for (int i = 0; i < 6; i++) begin
            tick();
            o = obs(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL hs_entry cyc%0d: got %b want %b", i, o, e); end
            if (i == 0) begin bus.hsclk_selected = 1'b1; bus.lsclk_selected = 1'b0; end
        end
    endtask

    // Continues from HS_RUN left by test_hs_entry.
    task automatic test_hs_exit();
        exp_t e, o;
        bus.fast_req = 1'b0;
        for (int i = 0; i < 2; i++) exp_q.push_back(mk(S_TLS, 1'b0, 1'b0, 2'b00, 1'b0));
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_THS, 1'b1, 1'b0, 2'b00, 1'b0));
        for (int i = 0; i < 8; i++) begin
            tick();
            o = obs(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL hs_exit cyc%0d: got %b want %b", i, o, e); end
            if (i == 0) bus.hsclk_selected = 1'b0;
            if (i == 1) bus.lsclk_selected = 1'b1;
            if (i == 2) bus.fast_req = 1'b1;
        end
    endtask

    task automatic test_timeout();
        exp_t e, o;
        do_reset();
        bus.fast_req = 1'b1; bus.en_hs = 1'b1;
        for (int i = 0; i < 15; i++) exp_q.push_back(mk(S_THS, 1'b1, 1'b0, 2'b00, 1'b0));
        exp_q.push_back(mk(S_TLS, 1'b0, 1'b0, 2'b00, 1'b1));
        for (int i = 0; i < 9; i++) exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b1));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_THS, 1'b1, 1'b0, 2'b00, 1'b0));
        for (int i = 0; i < 27; i++) begin
            tick();
            o = obs(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL timeout cyc%0d: got %b want %b", i, o, e); end
            if (i == 24) bus.err_clr = 1'b1;
            if (i == 25) bus.err_clr = 1'b0;
        end
    endtask

    task automatic test_err_priority();
        exp_t e, o;
        do_reset();
        bus.fast_req = 1'b1; bus.en_hs = 1'b1; bus.err_clr = 1'b1;
        for (int i = 0; i < 15; i++) exp_q.push_back(mk(S_THS, 1'b1, 1'b0, 2'b00, 1'b0));
        exp_q.push_back(mk(S_TLS, 1'b0, 1'b0, 2'b00, 1'b1));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        for (int i = 0; i < 17; i++) begin
            tick();
            o = obs(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL err_priority cyc%0d: got %b want %b", i, o, e); end
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic test_div_hs();
        exp_t e, o;
        do_reset();
        bus.fast_req = 1'b1; bus.en_hs = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(S_THS, 1'b1, 1'b0, 2'b00, 1'b0));
        exp_q.push_back(mk(S_HS, 1'b1, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_HS, 1'b1, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_TLS, 1'b0, 1'b0, 2'b00, 1'b0));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b11, 1'b0));
        for (int i = 0; i < 8; i++) begin
            tick();
            o = obs(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL div_hs cyc%0d: got %b want %b", i, o, e); end
            if (i == 0) begin bus.hsclk_selected = 1'b1; bus.lsclk_selected = 1'b0; end
            if (i == 3) begin bus.div_wr = 1'b1; bus.div_wdata = 2'b11; end
            if (i == 4) begin bus.div_wr = 1'b0; bus.fast_req = 1'b0; bus.hsclk_selected = 1'b0; end
            if (i == 5) bus.lsclk_selected = 1'b1;
        end
    endtask

    task automatic test_div_delay();
        exp_t e, o;
        do_reset();
        bus.div_wr = 1'b1; bus.div_wdata = 2'b10; bus.en_hs = 1'b1;
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b10, 1'b0));
        exp_q.push_back(mk(S_THS, 1'b1, 1'b0, 2'b10, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            o = obs(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL div_delay cyc%0d: got %b want %b", i, o, e); end
            if (i == 0) begin bus.div_wr = 1'b0; bus.fast_req = 1'b1; end
        end
    endtask

    task automatic test_div_refill();
        exp_t e, o;
        do_reset();
        bus.div_wr = 1'b1; bus.div_wdata = 2'b01;
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b01, 1'b0));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b10, 1'b0));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b10, 1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            o = obs(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL div_refill cyc%0d: got %b want %b", i, o, e); end
            if (i == 0) bus.div_wdata = 2'b10;
            if (i == 1) bus.div_wr = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        exp_t e, o;
        do_reset();
        bus.div_wr = 1'b1; bus.div_wdata = 2'b11; bus.en_hs = 1'b1;
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b11, 1'b0));
        exp_q.push_back(mk(S_THS, 1'b1, 1'b0, 2'b11, 1'b0));
        for (int i = 0; i < 3; i++) begin
            tick();
            o = obs(); e = exp_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL async_pre cyc%0d: got %b want %b", i, o, e); end
            if (i == 0) begin bus.div_wr = 1'b0; bus.fast_req = 1'b1; end
        end
        exp_q.push_back(mk(S_LS, 1'b0, 1'b1, 2'b00, 1'b0));
        #1 rst_b = 1'b0;
        #1;
        o = obs(); e = exp_q.pop_front(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL async_reset: got %b want %b", o, e); end
        bus.fast_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_hs_entry();
        test_hs_exit();
        test_timeout();
        test_err_priority();
        test_div_hs();
        test_div_delay();
        test_div_refill();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
